cache_fill: RTL

CACHE_FILL -- requirements
Module: cache_fill

---
 rtl/cache_fill_if.sv | 45 ++++
 rtl/cache_fill.sv | 103 ++++++++++
 2 files changed

// File: rtl/cache_fill_if.sv
// Bundle of the miss, memory-read, data-RAM write and fill-status signals of cache_fill.
// master = the fill engine; slave = the surrounding cache/memory environment.
interface cache_fill_if #(
    parameter int IDX = 6,
    parameter int OFS = 4,
    parameter int WOR = 32,
    parameter int TAG = 20
);
    logic           miss_req;
    logic [TAG-1:0] miss_tag;
    logic [IDX-1:0] miss_index;
    logic [OFS-1:0] miss_offset;

    // mem_req is held with a stable mem_addr until mem_ack is sampled high on a posedge;
    // each such cycle transfers exactly one word on mem_rdata, with no queuing of requests.
    logic           mem_req;
    logic [31:0]    mem_addr;
    logic           mem_ack;
    logic [WOR-1:0] mem_rdata;

    logic [IDX-1:0] ram_index;
    logic [OFS-1:0] ram_offset_write;
    logic [WOR-1:0] ram_data_in;
    logic           ram_do_write;

    logic           crit_valid;
    logic [WOR-1:0] crit_data;
    logic           fill_busy;
    logic           fill_done;

    // Encoded FSM state, for observation only.
    logic [1:0]     state_dbg;

    modport master (
        input  miss_req, miss_tag, miss_index, miss_offset, mem_ack, mem_rdata,
        output mem_req, mem_addr, ram_index, ram_offset_write, ram_data_in, ram_do_write,
               crit_valid, crit_data, fill_busy, fill_done, state_dbg
    );

    modport slave (
        output miss_req, miss_tag, miss_index, miss_offset, mem_ack, mem_rdata,
        input  mem_req, mem_addr, ram_index, ram_offset_write, ram_data_in, ram_do_write,
               crit_valid, crit_data, fill_busy, fill_done, state_dbg
    );
endinterface

// File: rtl/cache_fill.sv
// Cache line fill engine: fetches 2**OFS words per miss and writes them to the data RAM.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start fetching at the missed word instead of word 0.
module cache_fill #(
    parameter int IDX = 6,
    parameter int OFS = 4,
    parameter int WOR = 32,
    parameter int TAG = 20
) (
    input  logic          clock,
    input  logic          reset,
    cache_fill_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [OFS-1:0] OFS_ONE = OFS'(1);

    state_t         state_q, state_d;
    logic [TAG-1:0] tag_q;
    logic [IDX-1:0] idx_q;
    logic [OFS-1:0] miss_ofs_q;
    logic [OFS-1:0] cur_ofs_q;
    logic [OFS-1:0] count_q;
    logic [OFS-1:0] start_ofs;
    logic           ack_fetch;
    logic           last_ack;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_ofs = bus.miss_offset;
`else
    assign start_ofs = '0;
`endif

    // Acks outside FETCH never reach the datapath.
    assign ack_fetch = (state_q == FETCH) && bus.mem_ack;
    assign last_ack  = ack_fetch && (count_q == '1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.miss_req) state_d = FETCH;
            FETCH:   if (last_ack)     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q                <= '0;
            idx_q                <= '0;
            miss_ofs_q           <= '0;
            cur_ofs_q            <= '0;
            count_q              <= '0;
            bus.ram_index        <= '0;
            bus.ram_offset_write <= '0;
            bus.ram_data_in      <= '0;
            bus.ram_do_write     <= 1'b0;
            bus.crit_valid       <= 1'b0;
            bus.crit_data        <= '0;
        end else begin
            bus.ram_do_write <= 1'b0;
            bus.crit_valid   <= 1'b0;
            if ((state_q == IDLE) && bus.miss_req) begin
                tag_q      <= bus.miss_tag;
                idx_q      <= bus.miss_index;
                miss_ofs_q <= bus.miss_offset;
                cur_ofs_q  <= start_ofs;
                count_q    <= '0;
            end
            if (ack_fetch) begin
                bus.ram_index        <= idx_q;
                bus.ram_offset_write <= cur_ofs_q;
                bus.ram_data_in      <= bus.mem_rdata;
                bus.ram_do_write     <= 1'b1;
                cur_ofs_q            <= cur_ofs_q + OFS_ONE;
                count_q              <= count_q + OFS_ONE;
                // The missed word is forwarded alongside its RAM write.
                if (cur_ofs_q == miss_ofs_q) begin
                    bus.crit_valid <= 1'b1;
                    bus.crit_data  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req   = (state_q == FETCH);
    assign bus.mem_addr  = (state_q == FETCH) ? {tag_q, idx_q, cur_ofs_q, 2'b00} : 32'd0;
    assign bus.fill_busy = (state_q != IDLE);
    assign bus.fill_done = (state_q == DONE);
    assign bus.state_dbg = state_q;
endmodule
